// File: rtl/multicycle_exec_ctrl_if.sv
// Control/status bundle between the multicycle controller and the LEGv8 datapath.
// master = controller side, slave = datapath side.
interface multicycle_exec_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic             run;
  logic [10:0]      opcode;
  logic             zero;
  logic             mem_ready;
  logic             pc_write;
  logic             pc_src;
  logic             ir_write;
  logic             mem_read;
  logic             mem_write;
  logic             reg2_loc;
  logic             alu_src;
  logic [1:0]       alu_op;
  logic             reg_write;
  logic             mem_to_reg;
  logic             busy;
  logic             illegal;
  logic [2:0]       state;
  logic [CNT_W-1:0] retired;

  modport master (
    input  run, opcode, zero, mem_ready,
    output pc_write, pc_src, ir_write, mem_read, mem_write, reg2_loc, alu_src, alu_op,
           reg_write, mem_to_reg, busy, illegal, state, retired
  );

  modport slave (
    output run, opcode, zero, mem_ready,
    input  pc_write, pc_src, ir_write, mem_read, mem_write, reg2_loc, alu_src, alu_op,
           reg_write, mem_to_reg, busy, illegal, state, retired
  );
endinterface

// File: rtl/multicycle_exec_ctrl.sv
// Moore-style sequencer for the LEGv8 multicycle datapath: fetch, decode, execute,
// memory and write-back, with memory wait states, retire counting and illegal-opcode halt.
module multicycle_exec_ctrl #(
  parameter int unsigned CNT_W        = 16,
  parameter logic [1:0]  ALUOP_DTYPE  = 2'b00,
  parameter logic [1:0]  ALUOP_BRANCH = 2'b01,
  parameter logic [1:0]  ALUOP_RTYPE  = 2'b10
) (
  input  logic                   clk,
  input  logic                   reset_n,
  multicycle_exec_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFetch  = 3'd1,
    StDecode = 3'd2,
    StExec   = 3'd3,
    StMem    = 3'd4,
    StWb     = 3'd5,
    StHalt   = 3'd6
  } state_e;

  typedef enum logic [2:0] {OpNone, OpRtype, OpLdur, OpStur, OpCbz, OpB} op_class_e;

  function automatic op_class_e classify(input logic [10:0] op);
    op_class_e c;
    c = OpNone;
    if (op == 11'b10001011000 || op == 11'b11001011000 ||
        op == 11'b10001010000 || op == 11'b10101010000) begin
      c = OpRtype;
    end else if (op == 11'b11111000010) begin
      c = OpLdur;
    end else if (op == 11'b11111000000) begin
      c = OpStur;
    end else if (op[10:3] == 8'b10110100) begin
      c = OpCbz;
    end else if (op[10:5] == 6'b000101) begin
      c = OpB;
    end
    return c;
  endfunction

  state_e           state_q, state_d;
  logic [10:0]      op_q, op_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  op_class_e        dec_cls, exe_cls;
  logic             instr_end;

  assign dec_cls = classify(bus.opcode);
  assign exe_cls = classify(op_q);

  always_comb begin
    state_d        = state_q;
    op_d           = op_q;
    illegal_d      = illegal_q;
    retired_d      = retired_q;
    instr_end      = 1'b0;
    bus.pc_write   = 1'b0;
    bus.pc_src     = 1'b0;
    bus.ir_write   = 1'b0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.reg2_loc   = 1'b0;
    bus.alu_src    = 1'b0;
    bus.alu_op     = 2'b00;
    bus.reg_write  = 1'b0;
    bus.mem_to_reg = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.run) state_d = StFetch;
      end
      StFetch: begin
        bus.mem_read = 1'b1;
        if (bus.mem_ready) begin
          bus.ir_write = 1'b1;
          bus.pc_write = 1'b1;
          state_d      = StDecode;
        end
      end
      StDecode: begin
        // op_q is not valid yet, so the register-2 select decodes the live IR.
        op_d         = bus.opcode;
        bus.reg2_loc = (dec_cls == OpStur) || (dec_cls == OpCbz);
        if (dec_cls == OpNone) begin
          state_d   = StHalt;
          illegal_d = 1'b1;
        end else begin
          state_d = StExec;
        end
      end
      StExec: begin
        unique case (exe_cls)
          OpRtype: begin
            bus.alu_op = ALUOP_RTYPE;
            state_d    = StWb;
          end
          OpLdur, OpStur: begin
            bus.alu_op   = ALUOP_DTYPE;
            bus.alu_src  = 1'b1;
            bus.reg2_loc = (exe_cls == OpStur);
            state_d      = StMem;
          end
          OpCbz: begin
            bus.alu_op   = ALUOP_BRANCH;
            bus.reg2_loc = 1'b1;
            bus.pc_write = bus.zero;
            bus.pc_src   = bus.zero;
            instr_end    = 1'b1;
          end
          OpB: begin
            bus.pc_write = 1'b1;
            bus.pc_src   = 1'b1;
            instr_end    = 1'b1;
          end
          default: begin
            state_d   = StHalt;
            illegal_d = 1'b1;
          end
        endcase
      end
      StMem: begin
        bus.mem_write = (exe_cls == OpStur);
        bus.mem_read  = (exe_cls != OpStur);
        if (bus.mem_ready) begin
          if (exe_cls == OpStur) instr_end = 1'b1;
          else                   state_d   = StWb;
        end
      end
      StWb: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = (exe_cls == OpLdur);
        instr_end      = 1'b1;
      end
      StHalt: ;
      default: state_d = StIdle;
    endcase

    // Instruction boundary: the only place run is sampled after leaving IDLE.
    if (instr_end) begin
      retired_d = retired_q + CNT_W'(1);
      state_d   = bus.run ? StFetch : StIdle;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      op_q      <= '0;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      illegal_q <= illegal_d;
      retired_q <= retired_d;
    end
  end

  assign bus.state   = state_q;
  assign bus.busy    = (state_q != StIdle) && (state_q != StHalt);
  assign bus.illegal = illegal_q;
  assign bus.retired = retired_q;

endmodule

// File: tb/tb_multicycle_exec_ctrl.sv
// Directed bench for multicycle_exec_ctrl: per-cycle state, control-strobe and retire
// expectations for each instruction class, waits, illegal halt and reset behaviour.
module tb_multicycle_exec_ctrl;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_CBZ  = 11'b10110100101;
  localparam logic [10:0] OP_B    = 11'b00010100011;
  localparam logic [10:0] OP_BAD  = 11'b11111111111;

  // {pc_write, pc_src, ir_write, mem_read, mem_write, reg2_loc, alu_src, alu_op, reg_write, mem_to_reg}
  localparam logic [10:0] C_0   = 11'b00000000000;
  localparam logic [10:0] C_F   = 11'b10110000000;
  localparam logic [10:0] C_FW  = 11'b00010000000;
  localparam logic [10:0] C_D2  = 11'b00000100000;
  localparam logic [10:0] C_ER  = 11'b00000001000;
  localparam logic [10:0] C_ELD = 11'b00000010000;
  localparam logic [10:0] C_EST = 11'b00000110000;
  localparam logic [10:0] C_CBT = 11'b11000100100;
  localparam logic [10:0] C_CBN = 11'b00000100100;
  localparam logic [10:0] C_B   = 11'b11000000000;
  localparam logic [10:0] C_MLD = 11'b00010000000;
  localparam logic [10:0] C_MST = 11'b00001000000;
  localparam logic [10:0] C_WR  = 11'b00000000010;
  localparam logic [10:0] C_WL  = 11'b00000000011;

  logic clk;
  logic reset_n;
  int   n_cmp;
  int   n_err;

  multicycle_exec_ctrl_if #(.CNT_W(16)) bus ();

  multicycle_exec_ctrl #(.CNT_W(16)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [10:0] ctrl_vec();
    return {bus.pc_write, bus.pc_src, bus.ir_write, bus.mem_read, bus.mem_write,
            bus.reg2_loc, bus.alu_src, bus.alu_op, bus.reg_write, bus.mem_to_reg};
  endfunction

  // Leaves the DUT in IDLE, 1 ns after a rising edge, with run=0.
  task automatic do_reset();
    reset_n       = 1'b0;
    bus.run       = 1'b0;
    bus.opcode    = '0;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n       = 1'b0;
    bus.run       = 1'b1;
    bus.opcode    = OP_ADD;
    bus.mem_ready = 1'b1;
    bus.zero      = 1'b0;
    #1;
    n_cmp++;
    if (bus.state !== 3'd0) begin
      n_err++; $display("FAIL reset_state: got %0d want 0", bus.state);
    end
    n_cmp++;
    if (ctrl_vec() !== C_0) begin
      n_err++; $display("FAIL reset_ctrl: got %b want %b", ctrl_vec(), C_0);
    end
    n_cmp++;
    if ({bus.busy, bus.illegal, bus.retired} !== 18'd0) begin
      n_err++; $display("FAIL reset_status: busy %b illegal %b retired %0d want 0 0 0",
                        bus.busy, bus.illegal, bus.retired);
    end
    do_reset();
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (bus.state !== 3'd0 || ctrl_vec() !== C_0) begin
        n_err++; $display("FAIL idle_hold[%0d]: state %0d ctrl %b want 0 %b",
                          i, bus.state, ctrl_vec(), C_0);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_add();
    logic [2:0]  st [5] = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd1};
    logic [10:0] cv [5] = '{C_F, C_0, C_ER, C_WR, C_F};
    logic [15:0] rt [5] = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd1};
    do_reset();
    bus.run = 1'b1; bus.opcode = OP_ADD; bus.mem_ready = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_cmp++;
      if (bus.state !== st[i]) begin
        n_err++; $display("FAIL add_state[%0d]: got %0d want %0d", i, bus.state, st[i]);
      end
      n_cmp++;
      if (ctrl_vec() !== cv[i]) begin
        n_err++; $display("FAIL add_ctrl[%0d]: got %b want %b", i, ctrl_vec(), cv[i]);
      end
      n_cmp++;
      if (bus.retired !== rt[i]) begin
        n_err++; $display("FAIL add_retired[%0d]: got %0d want %0d", i, bus.retired, rt[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_ldur_wait();
    logic [2:0]  st [8] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4, 3'd5, 3'd1};
    logic        mr [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [10:0] cv [8] = '{C_F, C_0, C_ELD, C_MLD, C_MLD, C_MLD, C_WL, C_F};
    logic [15:0] rt [8] = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd1};
    do_reset();
    bus.run = 1'b1; bus.opcode = OP_LDUR;
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      bus.mem_ready = mr[i];
      #1;
      n_cmp++;
      if (bus.state !== st[i]) begin
        n_err++; $display("FAIL ldur_state[%0d]: got %0d want %0d", i, bus.state, st[i]);
      end
      n_cmp++;
      if (ctrl_vec() !== cv[i]) begin
        n_err++; $display("FAIL ldur_ctrl[%0d]: got %b want %b", i, ctrl_vec(), cv[i]);
      end
      n_cmp++;
      if (bus.retired !== rt[i]) begin
        n_err++; $display("FAIL ldur_retired[%0d]: got %0d want %0d", i, bus.retired, rt[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_stur();
    logic [2:0]  st [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd1};
    logic [10:0] cv [5] = '{C_F, C_D2, C_EST, C_MST, C_F};
    logic [15:0] rt [5] = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd1};
    do_reset();
    bus.run = 1'b1; bus.opcode = OP_STUR; bus.mem_ready = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_cmp++;
      if (bus.state !== st[i]) begin
        n_err++; $display("FAIL stur_state[%0d]: got %0d want %0d", i, bus.state, st[i]);
      end
      n_cmp++;
      if (ctrl_vec() !== cv[i]) begin
        n_err++; $display("FAIL stur_ctrl[%0d]: got %b want %b", i, ctrl_vec(), cv[i]);
      end
      n_cmp++;
      if (bus.retired !== rt[i]) begin
        n_err++; $display("FAIL stur_retired[%0d]: got %0d want %0d", i, bus.retired, rt[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_cbz();
    logic [2:0]  st [7] = '{3'd1, 3'd2, 3'd3, 3'd1, 3'd2, 3'd3, 3'd1};
    logic        zf [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [10:0] cv [7] = '{C_F, C_D2, C_CBT, C_F, C_D2, C_CBN, C_F};
    logic [15:0] rt [7] = '{16'd0, 16'd0, 16'd0, 16'd1, 16'd1, 16'd1, 16'd2};
    do_reset();
    bus.run = 1'b1; bus.opcode = OP_CBZ; bus.mem_ready = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 7; i++) begin
      bus.zero = zf[i];
      #1;
      n_cmp++;
      if (bus.state !== st[i]) begin
        n_err++; $display("FAIL cbz_state[%0d]: got %0d want %0d", i, bus.state, st[i]);
      end
      n_cmp++;
      if (ctrl_vec() !== cv[i]) begin
        n_err++; $display("FAIL cbz_ctrl[%0d]: got %b want %b", i, ctrl_vec(), cv[i]);
      end
      n_cmp++;
      if (bus.retired !== rt[i]) begin
        n_err++; $display("FAIL cbz_retired[%0d]: got %0d want %0d", i, bus.retired, rt[i]);
      end
      @(posedge clk); #1;
    end
    bus.zero = 1'b0;
  endtask

  // B followed by AND with one fetch wait state between them.
  task automatic test_back_to_back();
    logic [2:0]  st [9] = '{3'd1, 3'd2, 3'd3, 3'd1, 3'd1, 3'd2, 3'd3, 3'd5, 3'd1};
    logic        mr [9] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [10:0] op [9] = '{OP_B, OP_B, OP_B, OP_AND, OP_AND, OP_AND, OP_AND, OP_AND, OP_AND};
    logic [10:0] cv [9] = '{C_F, C_0, C_B, C_FW, C_F, C_0, C_ER, C_WR, C_F};
    logic [15:0] rt [9] = '{16'd0, 16'd0, 16'd0, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd2};
    do_reset();
    bus.run = 1'b1; bus.opcode = OP_B;
    @(posedge clk); #1;
    for (int i = 0; i < 9; i++) begin
      bus.mem_ready = mr[i];
      bus.opcode    = op[i];
      #1;
      n_cmp++;
      if (bus.state !== st[i]) begin
        n_err++; $display("FAIL b2b_state[%0d]: got %0d want %0d", i, bus.state, st[i]);
      end
      n_cmp++;
      if (ctrl_vec() !== cv[i]) begin
        n_err++; $display("FAIL b2b_ctrl[%0d]: got %b want %b", i, ctrl_vec(), cv[i]);
      end
      n_cmp++;
      if (bus.retired !== rt[i]) begin
        n_err++; $display("FAIL b2b_retired[%0d]: got %0d want %0d", i, bus.retired, rt[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_illegal();
    logic [2:0]  st [5] = '{3'd1, 3'd2, 3'd6, 3'd6, 3'd6};
    logic [10:0] cv [5] = '{C_F, C_0, C_0, C_0, C_0};
    logic        il [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic        bz [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    do_reset();
    bus.run = 1'b1; bus.opcode = OP_BAD; bus.mem_ready = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_cmp++;
      if (bus.state !== st[i]) begin
        n_err++; $display("FAIL illegal_state[%0d]: got %0d want %0d", i, bus.state, st[i]);
      end
      n_cmp++;
      if (ctrl_vec() !== cv[i]) begin
        n_err++; $display("FAIL illegal_ctrl[%0d]: got %b want %b", i, ctrl_vec(), cv[i]);
      end
      n_cmp++;
      if (bus.illegal !== il[i] || bus.busy !== bz[i]) begin
        n_err++; $display("FAIL illegal_flags[%0d]: illegal %b busy %b want %b %b",
                          i, bus.illegal, bus.busy, il[i], bz[i]);
      end
      @(posedge clk); #1;
    end
    do_reset();
    n_cmp++;
    if (bus.state !== 3'd0 || bus.illegal !== 1'b0 || bus.retired !== 16'd0) begin
      n_err++; $display("FAIL illegal_exit: state %0d illegal %b retired %0d want 0 0 0",
                        bus.state, bus.illegal, bus.retired);
    end
  endtask

  task automatic test_run_drop();
    logic [2:0]  st [6] = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd0, 3'd0};
    logic        rn [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [10:0] cv [6] = '{C_F, C_0, C_ER, C_WR, C_0, C_0};
    logic [15:0] rt [6] = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd1, 16'd1};
    logic        bz [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    do_reset();
    bus.run = 1'b1; bus.opcode = OP_SUB; bus.mem_ready = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) begin
      bus.run = rn[i];
      #1;
      n_cmp++;
      if (bus.state !== st[i]) begin
        n_err++; $display("FAIL rundrop_state[%0d]: got %0d want %0d", i, bus.state, st[i]);
      end
      n_cmp++;
      if (ctrl_vec() !== cv[i] || bus.busy !== bz[i]) begin
        n_err++; $display("FAIL rundrop_ctrl[%0d]: got %b busy %b want %b busy %b",
                          i, ctrl_vec(), bus.busy, cv[i], bz[i]);
      end
      n_cmp++;
      if (bus.retired !== rt[i]) begin
        n_err++; $display("FAIL rundrop_retired[%0d]: got %0d want %0d", i, bus.retired, rt[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  // Starts from IDLE with retired=1 left by test_run_drop.
  task automatic test_reset_mid_mem();
    logic [2:0]  st [4] = '{3'd1, 3'd2, 3'd3, 3'd4};
    logic        mr [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [10:0] cv [4] = '{C_F, C_0, C_ELD, C_MLD};
    bus.run = 1'b1; bus.opcode = OP_LDUR;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      bus.mem_ready = mr[i];
      #1;
      n_cmp++;
      if (bus.state !== st[i] || ctrl_vec() !== cv[i] || bus.retired !== 16'd1) begin
        n_err++; $display("FAIL midmem_seq[%0d]: state %0d ctrl %b retired %0d want %0d %b 1",
                          i, bus.state, ctrl_vec(), bus.retired, st[i], cv[i]);
      end
      if (i < 3) begin
        @(posedge clk); #1;
      end
    end
    #3;
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.state !== 3'd0) begin
      n_err++; $display("FAIL midmem_reset_state: got %0d want 0", bus.state);
    end
    n_cmp++;
    if (ctrl_vec() !== C_0 || bus.busy !== 1'b0 || bus.retired !== 16'd0) begin
      n_err++; $display("FAIL midmem_reset_out: ctrl %b busy %b retired %0d want %b 0 0",
                        ctrl_vec(), bus.busy, bus.retired, C_0);
    end
    do_reset();
  endtask

  initial begin
    n_cmp         = 0;
    n_err         = 0;
    reset_n       = 1'b0;
    bus.run       = 1'b0;
    bus.opcode    = '0;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b0;
    #2;
    test_reset();
    test_add();
    test_ldur_wait();
    test_stur();
    test_cbz();
    test_back_to_back();
    test_illegal();
    test_run_drop();
    test_reset_mid_mem();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/multicycle_exec_ctrl.md
Name: multicycle_exec_ctrl

Overview:
- Moore-style control FSM that sequences the LEGv8 multicycle datapath: instruction fetch, decode, execute stage (ALU + branch target), memory access and write-back.
- Drives alu_op/alu_src into the execute stage and consumes its zero flag.
- Handles memory wait states via mem_ready.
- Counts retired instructions and halts on undecodable opcodes.

Parameters:
- CNT_W, 16, width of the retired-instruction counter.
- ALUOP_DTYPE, 2'b00, ALUOp for LDUR/STUR address add.
- ALUOP_BRANCH, 2'b01, ALUOp for CBZ pass/compare.
- ALUOP_RTYPE, 2'b10, ALUOp for R-type (function from opcode).

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- run  in  1  level; 1 = keep executing, 0 = stop at the next instruction boundary.
- opcode  in  11  instruction[31:21] from the IR.
- zero  in  1  ALU zero flag from the execute stage.
- mem_ready  in  1  memory completes the current access this cycle.
- pc_write  out  1  update PC.
- pc_src  out  1  0 = PC+4, 1 = branch_target.
- ir_write  out  1  load IR from memory.
- mem_read  out  1  memory read request (fetch or LDUR).
- mem_write  out  1  memory write request (STUR).
- reg2_loc  out  1  1 = read register 2 from Rt (STUR/CBZ).
- alu_src  out  1  1 = sign-extended immediate.
- alu_op  out  2  ALUOp to the execute stage.
- reg_write  out  1  register file write enable.
- mem_to_reg  out  1  write-back source 1 = memory data.
- busy  out  1  state not IDLE/HALT.
- illegal  out  1  sticky; set in HALT.
- state  out  3  current state code.
- retired  out  CNT_W  retired-instruction count.

Behaviour:
- Reset (async, reset_n=0): state=IDLE; all control outputs 0; alu_op=00; illegal=0; retired=0; op_q=0.
- States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6.
- IDLE: go to FETCH when run=1, else stay.
- FETCH: mem_read=1.
  - mem_ready=0: hold FETCH.
  - mem_ready=1: ir_write=1, pc_write=1, pc_src=0, then go to DECODE.
- DECODE: latch op_q=opcode.
  - Recognised opcodes: ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000, LDUR 11111000010, STUR 11111000000, CBZ 10110100xxx, B 000101xxxxx.
  - Recognised -> EXEC. Anything else -> HALT and set illegal.
  - reg2_loc=1 for STUR/CBZ.
- EXEC: outputs decoded from op_q.
  - R-type: alu_op=RTYPE, alu_src=0 -> WB.
  - LDUR/STUR: alu_op=DTYPE, alu_src=1 -> MEM.
  - CBZ: alu_op=BRANCH, alu_src=0, reg2_loc=1. If zero=1: pc_write=1, pc_src=1. Ends instruction.
  - B: pc_write=1, pc_src=1 unconditionally. Ends instruction.
- MEM:
  - LDUR: mem_read=1. STUR: mem_write=1.
  - Hold while mem_ready=0.
  - On mem_ready: LDUR -> WB; STUR ends instruction.
- WB: reg_write=1; mem_to_reg=1 only for LDUR. Ends instruction.
- Instruction end: retired increments by 1 (wraps modulo 2^CNT_W). Next state is FETCH if run=1, else IDLE.
- run dropping mid-instruction does not abort; the current instruction completes.
- Cycle counts with mem_ready=1: R-type 4, LDUR 5, STUR 4, CBZ 3, B 3.
- Each mem_ready=0 cycle in FETCH/MEM adds exactly 1 cycle. Control outputs stay constant during the wait; no write strobe repeats except mem_write held with the request.
- HALT: all strobes 0; illegal=1; exit only via reset.
- All outputs are registered-state decodes; no combinational path from mem_ready/zero to state except pc_write/ir_write/pc_src qualification as specified above.

Test Plan:
- Reset, run=1, mem_ready=1, opcode=ADD -> states 1,2,3,5,1; alu_op=10 in EXEC; reg_write=1 in WB only; retired 0->1 after 4 cycles.
- LDUR, mem_ready low for 2 cycles in MEM -> EXEC alu_src=1, alu_op=00; MEM held 3 cycles with mem_read=1; WB mem_to_reg=1; total 7 cycles.
- STUR -> mem_write=1 for exactly one MEM cycle, reg_write never 1, reg2_loc=1 in DECODE/EXEC, back to FETCH after 4 cycles.
- CBZ with zero=1, then CBZ with zero=0 -> first: pc_write=1, pc_src=1 in EXEC; second: pc_write=0 in EXEC; each 3 cycles.
- opcode=11 bits all 1 -> HALT at cycle 3, illegal=1, busy=0, stays until reset_n pulse returns IDLE with retired=0.
- run deasserted during EXEC of SUB -> instruction completes through WB, retired increments, state=IDLE; asserting reset_n=0 mid-MEM clears all outputs immediately.
